// File: rtl/info_frame_pkg.sv
// Shared types and constants for InfoFrame packet sources.
package info_frame_pkg;
    localparam int INFO_FRAME_MAX_PB = 27;

    typedef logic [7:0] pb_t;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        LOAD,
        PUBLISH
    } info_frame_state_t;

    localparam logic [6:0] AVI   = 7'd2;
    localparam logic [6:0] SPD   = 7'd3;
    localparam logic [6:0] AUDIO = 7'd4;
endpackage

// File: rtl/info_frame_checksum_acc.sv
// Modulo-256 byte accumulator; with finish high the result is the two's-complement checksum.
module info_frame_checksum_acc
    import info_frame_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  pb_t  init_value,
    input  logic add,
    input  pb_t  add_value,
    input  logic finish,
    output pb_t  result
);
    pb_t sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (init) begin
            sum <= init_value;
        end else if (add) begin
            sum <= 8'(sum + add_value);
        end
    end

    assign result = finish ? 8'(~sum + 8'd1) : sum;
endmodule

// File: rtl/info_frame_builder.sv
// Runtime-programmable InfoFrame source: shadow payload, sequential checksum,
// atomic swap into the active set that drives the packet assembler.
module info_frame_builder
    import info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE       = 7'd2,
    parameter logic [7:0] VERSION    = 8'd2,
    parameter int         MAX_LENGTH = 27
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [4:0]        length,
    input  logic              commit,
    output logic              busy,
    output logic              frame_valid,
    output logic              packet_update,
    output logic [23:0]       header,
    output logic [3:0][55:0]  sub
);
    localparam logic [4:0] MAX_LEN = 5'(MAX_LENGTH);
    localparam pb_t        HB0     = {1'b1, TYPE};

    info_frame_state_t state, state_next, commit_target;

    pb_t        shadow [1:INFO_FRAME_MAX_PB];
    pb_t        active [0:INFO_FRAME_MAX_PB];
    logic [4:0] active_len;
    logic [4:0] len_q;
    logic [4:0] idx;
    logic [4:0] len_clamped;
    logic       acc_init, acc_add, acc_finish;
    pb_t        acc_init_value, acc_result;

    assign len_clamped    = (length > MAX_LEN) ? MAX_LEN : length;
    assign acc_init_value = 8'(HB0 + VERSION + {3'b000, len_clamped});
    assign commit_target  = (len_clamped != 5'd0) ? SUM : LOAD;

    assign busy          = (state == SUM) || (state == LOAD);
    assign packet_update = (state == PUBLISH);
    assign header        = {3'b000, active_len, VERSION, HB0};

    info_frame_checksum_acc u_acc (
        .clk        (clk_pixel),
        .reset      (reset),
        .init       (acc_init),
        .init_value (acc_init_value),
        .add        (acc_add),
        .add_value  (shadow[idx]),
        .finish     (acc_finish),
        .result     (acc_result)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PUBLISH is not busy, so a new commit may be accepted there directly.
    always_comb begin
        state_next = state;
        acc_init   = 1'b0;
        acc_add    = 1'b0;
        acc_finish = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    acc_init   = 1'b1;
                    state_next = commit_target;
                end
            end
            SUM: begin
                acc_add = 1'b1;
                if (idx == len_q) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                acc_finish = 1'b1;
                state_next = PUBLISH;
            end
            PUBLISH: begin
                if (commit) begin
                    acc_init   = 1'b1;
                    state_next = commit_target;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            len_q       <= '0;
            idx         <= '0;
            active_len  <= '0;
            frame_valid <= 1'b0;
            for (int j = 1; j <= INFO_FRAME_MAX_PB; j++) begin
                shadow[j] <= '0;
            end
            for (int j = 0; j <= INFO_FRAME_MAX_PB; j++) begin
                active[j] <= '0;
            end
        end else begin
            if (wr_en && !busy && wr_addr != 5'd0 && wr_addr <= MAX_LEN) begin
                shadow[wr_addr] <= wr_data;
            end
            if (acc_init) begin
                len_q <= len_clamped;
                idx   <= 5'd1;
            end else if (acc_add) begin
                idx <= idx + 5'd1;
            end
            // The whole active set swaps in one edge so consumers never see a torn frame.
            if (state == LOAD) begin
                active[0] <= acc_result;
                for (int j = 1; j <= INFO_FRAME_MAX_PB; j++) begin
                    active[j] <= (5'(j) <= len_q) ? shadow[j] : 8'h00;
                end
                active_len  <= len_q;
                frame_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 7; b++) begin
                sub[i][8*b +: 8] = active[7*i + b];
            end
        end
    end
endmodule

// File: tb/tb_info_frame_builder.sv
// Scoreboard bench for info_frame_builder: directed test-plan cases followed by random traffic.
module tb_info_frame_builder;
    import info_frame_pkg::*;

    localparam logic [6:0] TYPE       = 7'd2;
    localparam logic [7:0] VERSION    = 8'd2;
    localparam int         MAX_LENGTH = 27;
    localparam logic [23:0] RESET_HDR = {8'h00, VERSION, 1'b1, TYPE};

    logic             clk_pixel = 1'b0;
    logic             reset     = 1'b1;
    logic             wr_en     = 1'b0;
    logic [4:0]       wr_addr   = '0;
    logic [7:0]       wr_data   = '0;
    logic [4:0]       length    = '0;
    logic             commit    = 1'b0;
    logic             busy;
    logic             frame_valid;
    logic             packet_update;
    logic [23:0]      header;
    logic [3:0][55:0] sub;

    info_frame_builder #(
        .TYPE       (TYPE),
        .VERSION    (VERSION),
        .MAX_LENGTH (MAX_LENGTH)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .length        (length),
        .commit        (commit),
        .busy          (busy),
        .frame_valid   (frame_valid),
        .packet_update (packet_update),
        .header        (header),
        .sub           (sub)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int               due;
        logic [23:0]      hdr;
        logic [3:0][55:0] sb;
    } frame_t;

    frame_t           exp_q[$];
    logic [7:0]       shadow_m [1:27];
    int               cyc        = 0;
    int               free_cycle = 0;
    int               busy_start = 0;
    logic [23:0]      cur_hdr    = RESET_HDR;
    logic [3:0][55:0] cur_sub    = '0;
    logic             cur_fv     = 1'b0;
    logic             mon_en     = 1'b0;
    int               checks     = 0;
    int               failures   = 0;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected frame straight from the rules: zero-padded payload, checksum makes the total 0 mod 256.
    function automatic frame_t build(input int len, input int due);
        frame_t     f;
        logic [7:0] pb [0:27];
        int         sum;
        sum = int'({1'b1, TYPE}) + int'(VERSION) + len;
        for (int j = 1; j <= 27; j++) begin
            pb[j] = (j <= len) ? shadow_m[j] : 8'h00;
            sum += int'(pb[j]);
        end
        pb[0] = 8'((256 - (sum % 256)) % 256);
        f.due = due;
        f.hdr = {3'b000, 5'(len), VERSION, 1'b1, TYPE};
        f.sb  = '0;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 7; b++)
                f.sb[i][8*b +: 8] = pb[7*i + b];
        return f;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int j = 1; j <= 27; j++) shadow_m[j] = 8'h00;
        free_cycle = 0;
        busy_start = 0;
        cur_hdr    = RESET_HDR;
        cur_sub    = '0;
        cur_fv     = 1'b0;
    endtask

    // Drives one cycle of inputs (called at posedge+1) and updates the model.
    task automatic drive_cycle(input logic we, input logic [4:0] addr, input logic [7:0] data,
                               input logic cm, input logic [4:0] len);
        int l;
        wr_en = we; wr_addr = addr; wr_data = data; commit = cm; length = len;
        if (cyc >= free_cycle) begin
            if (we && int'(addr) >= 1 && int'(addr) <= MAX_LENGTH) shadow_m[addr] = data;
            if (cm) begin
                l = (int'(len) > MAX_LENGTH) ? MAX_LENGTH : int'(len);
                exp_q.push_back(build(l, cyc + l + 2));
                busy_start = cyc + 1;
                free_cycle = cyc + l + 2;
            end
        end
        @(posedge clk_pixel); #1;
        wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk_pixel) begin
        if (mon_en) begin
            frame_t f;
            if (packet_update) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet_update", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    chk("publish_cycle", cyc, f.due);
                    cur_hdr = f.hdr; cur_sub = f.sb; cur_fv = 1'b1;
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("missing_packet_update", 0, 1);
                f = exp_q.pop_front();
                cur_hdr = f.hdr; cur_sub = f.sb; cur_fv = 1'b1;
            end
            chk("header", header, cur_hdr);
            chk("sub", sub, cur_sub);
            chk("frame_valid", frame_valid, cur_fv);
            chk("busy", busy, (cyc >= busy_start && cyc < free_cycle));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk_pixel);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("reset_header", header, 24'h000282);
        chk("reset_busy", busy, 0);
        chk("reset_frame_valid", frame_valid, 0);
        chk("reset_packet_update", packet_update, 0);

        // L=0 right after reset
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd0);
        idle(1);
        chk("l0_packet_update", packet_update, 1);
        chk("l0_header", header, 24'h000282);
        chk("l0_pb0", sub[0][7:0], 8'h7C);
        chk("l0_frame_valid", frame_valid, 1);

        // AVI frame
        do_reset();
        drive_cycle(1'b1, 5'd1, 8'h10, 1'b0, 5'd0);
        drive_cycle(1'b1, 5'd2, 8'h28, 1'b0, 5'd0);
        drive_cycle(1'b1, 5'd3, 8'h08, 1'b0, 5'd0);
        drive_cycle(1'b1, 5'd4, 8'h04, 1'b0, 5'd0);
        drive_cycle(1'b1, 5'd5, 8'h00, 1'b0, 5'd0);
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd13);
        idle(14);
        chk("avi_packet_update", packet_update, 1);
        chk("avi_header", header, 24'h0D0282);
        chk("avi_sub0", sub[0], 56'h0000040828102B);
        chk("avi_sub123", sub[3:1], 168'h0);

        // Rewrite PB4 and recommit: old frame holds through cycle 14
        drive_cycle(1'b1, 5'd4, 8'h10, 1'b0, 5'd0);
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd13);
        idle(13);
        chk("rewrite_old_pb0", sub[0][7:0], 8'h2B);
        idle(1);
        chk("rewrite_new_pb0", sub[0][7:0], 8'h1F);

        // Write and commit while busy are both dropped
        idle(2);
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd13);
        idle(2);
        drive_cycle(1'b1, 5'd2, 8'hFF, 1'b1, 5'd5);
        idle(12);
        chk("busy_pb2_kept", sub[0][23:16], 8'h28);
        chk("busy_pb0", sub[0][7:0], 8'h1F);
        idle(20);

        // Length clamp
        for (int j = 1; j <= 27; j++) drive_cycle(1'b1, 5'(j), 8'($urandom), 1'b0, 5'd0);
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd31);
        idle(28);
        chk("clamp_hb2", header[23:16], 8'h1B);

        // Reset in cycle 5 of an L=13 build
        drive_cycle(1'b0, 5'd0, 8'h00, 1'b1, 5'd13);
        idle(4);
        do_reset();
        chk("midreset_busy", busy, 0);
        chk("midreset_frame_valid", frame_valid, 0);
        chk("midreset_packet_update", packet_update, 0);
        chk("midreset_header", header, RESET_HDR);
        chk("midreset_sub", sub, 224'h0);
        idle(20);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
                            ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)));
            end
        end
        idle(40);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/info_frame_builder.md
# info_frame_builder

Runtime-programmable, parametrised HDMI InfoFrame source: software/control logic writes payload bytes PB1..PBn into a shadow buffer, then commits. The block computes the checksum sequentially, atomically swaps the frame into an active register set, and drives the packet-assembler-facing `header`/`sub` buses. It generalises the fixed-parameter AVI InfoFrame to any InfoFrame type, with a runtime length and tear-free updates. It sits in the pixel clock domain beside the HDMI packet picker.

## Interface
- `TYPE`, 7'd2: InfoFrame type code; header byte HB0 = {1'b1, TYPE}.
- `VERSION`, 8'd2: HB1.
- `MAX_LENGTH`, 27: payload bytes supported (1..27); `length` is clamped to this.
- `clk_pixel`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  write `wr_data` to shadow PB[`wr_addr`].
- `wr_addr`  in  5  payload index 1..MAX_LENGTH; 0 or >MAX_LENGTH is ignored.
- `wr_data`  in  8  payload byte.
- `length`  in  5  payload length, sampled on the `commit` cycle.
- `commit`  in  1  single-cycle request to build and publish the frame.
- `busy`  out  1  build in progress; writes and commits are ignored.
- `frame_valid`  out  1  high once the first frame is published; sticky until reset.
- `packet_update`  out  1  one-cycle pulse in the first cycle the new outputs are visible.
- `header`  out  24  {3'b0, active_len, VERSION, 1'b1, TYPE}.
- `sub`  out  [3:0] x 56  sub[i] = {PB[6+7i] … PB[7i]}; PB0 = checksum.

## Operation
- The shadow buffer holds PB1..PBMAX_LENGTH and is writable only in IDLE. A write and a commit in the same cycle: the write is included in the build.
- FSM states:
  - IDLE: on `commit`, latch L = min(`length`, MAX_LENGTH); initialise acc = HB0 + HB1 + {3'b0, L}. Go to SUM if L>0, else LOAD.
  - SUM: add shadow PB[k] for k = 1..L, one byte per cycle, with a 5-bit index counter. After k = L, go to LOAD.
  - LOAD: checksum = 8'(~acc + 1). Copy PB1..PBL to the active set and zero active PB(L+1)..PB27. Set active_len = L, set `frame_valid`, go to PUBLISH.
  - PUBLISH: pulse `packet_update`, return to IDLE.
- All sums are 8-bit modulo 256. Invariant: HB0+HB1+HB2+PB0+…+PB27 ≡ 0 (mod 256).
- Active registers change only in LOAD, so consumers never see a partially updated frame.
- `commit` while `busy` is dropped and not queued. Shadow contents persist across commits.

## Timing
- Commit accepted at cycle 0. `busy` is high in cycles 1..L+1. The active set is registered at the end of LOAD (cycle L+1). `packet_update` and the new `header`/`sub` are visible in cycle L+2, and `busy` is low in that cycle.
- Latency from commit to visible frame is L+2 cycles; for L=0 it is 2 cycles.
- Reset values:
  - `busy` = 0, `frame_valid` = 0, `packet_update` = 0.
  - Shadow and active PB = 0; active_len = 0.
  - `header` = {8'h00, VERSION, 1'b1, TYPE}; `sub` = all zero.
  - FSM state = IDLE.
- Reset mid-build aborts immediately, and all outputs take their reset values on the next cycle.
- Back-to-back commits: the next commit is accepted no earlier than cycle L+2, the PUBLISH cycle, when `busy` is already low.

## Structure
- Package `info_frame_pkg` holds:
  - `INFO_FRAME_MAX_PB` = 27
  - typedef `pb_t` (logic [7:0])
  - enum `info_frame_state_t` {IDLE, SUM, LOAD, PUBLISH}
  - type codes AVI = 2, SPD = 3, AUDIO = 4
- One sub-module, `info_frame_checksum_acc`: an 8-bit accumulator with init, add and finish/negate controls. It is reusable by other packet sources.
- Shadow and active sets are flat register arrays, not RAM, because every active byte drives `sub` in parallel.

## Test plan
- AVI frame: TYPE=2, VERSION=2, L=13, PB1..PB5 = 10,28,08,04,00, rest zero, then commit → cycle 15: `header`=24'h0D0282, PB0=8'h2B, sub[0]=56'h0000040828102B, sub[1..3]=0, one `packet_update`.
- L=0 commit after reset → cycle 2: `header`=24'h000282, PB0=8'h7C, `frame_valid`=1.
- Rewrite PB4=0x10 and recommit L=13 → PB0=8'h1F. `sub` holds the old value through cycle 14 and changes only at cycle 15.
- `length`=31 → clamped to 27: HB2=8'h1B, PB1..PB27 all included; checksum recomputed by the model.
- During `busy`: `wr_en` to PB2 and a second `commit` → both ignored, PB2 unchanged, exactly one `packet_update`.
- `reset` asserted at cycle 5 of an L=13 build → next cycle shows all reset values, with no `packet_update` pulse and `frame_valid`=0.
